// File: rtl/sampler_axi_pkg.sv
// Shared types and constants for the sampler DMA AXI4-Lite slave.
package sampler_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int unsigned ADDR_LSB = 2;

  typedef enum logic [1:0] {W_IDLE, W_STROBE, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID}  rd_state_t;

  function automatic logic in_space(input logic [31:0] word_addr, input int unsigned words);
    return word_addr < words;
  endfunction

endpackage

// File: rtl/sampler_axi_lite_rd_ch.sv
// Read channel of the sampler AXI4-Lite slave: AR/R FSM, read address register, data capture.
// Optional out-of-range SLVERR handling under SAMPLER_AXI_SLVERR_EN.
module sampler_axi_lite_rd_ch
  import sampler_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 12,
  parameter int unsigned OPT_MEM_ADDR_BITS = 10,
  parameter int unsigned REG_SPACE_WORDS   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [OPT_MEM_ADDR_BITS-1:0] reg_addr_rd_o,
  input  logic [DATA_WIDTH-1:0]        reg_data_out_i
);

  rd_state_t                    state_q, state_d;
  logic                         arready_q, arready_d;
  logic [OPT_MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic                         unused_bits;

`ifdef SAMPLER_AXI_SLVERR_EN
  assign unused_bits = ^araddr_i;
`else
  assign unused_bits = ^{araddr_i, 32'(REG_SPACE_WORDS)};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (state_q)
      R_IDLE: begin
        if (arvalid_i && arready_q) begin
          addr_d  = araddr_i[ADDR_LSB +: OPT_MEM_ADDR_BITS];
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rdata_d = reg_data_out_i;
        rresp_d = AXI_RESP_OKAY;
`ifdef SAMPLER_AXI_SLVERR_EN
        if (!in_space(32'(addr_q), REG_SPACE_WORDS)) begin
          rdata_d = '0;
          rresp_d = AXI_RESP_SLVERR;
        end
`endif
        state_d = R_VALID;
      end
      R_VALID: begin
        if (rready_i) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
    // arready is registered so it reads 0 while in reset
    arready_d = (state_d == R_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= R_IDLE;
      arready_q <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign arready_o     = arready_q;
  assign rvalid_o      = (state_q == R_VALID);
  assign rdata_o       = rdata_q;
  assign rresp_o       = rresp_q;
  assign reg_addr_rd_o = addr_q;

endmodule

// File: rtl/sampler_axi_lite_slave.sv
// AXI4-Lite slave front end for the sampler DMA register file; write channel lives here.
// Define SAMPLER_AXI_SLVERR_EN to answer out-of-range accesses with SLVERR.
module sampler_axi_lite_slave
  import sampler_axi_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
  parameter int unsigned OPT_MEM_ADDR_BITS  = 10,
  parameter int unsigned REG_SPACE_WORDS    = 32
) (
  input  logic                            axi_clk,
  input  logic                            axi_reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg_data_in,
  output logic [OPT_MEM_ADDR_BITS-1:0]    reg_addr_wr,
  output logic                            reg_data_wren,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] reg_byte_enable,
  output logic [OPT_MEM_ADDR_BITS-1:0]    reg_addr_rd,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   reg_data_out
);

  wr_state_t                       wr_state_q, wr_state_d;
  logic                            aw_lat_q, aw_lat_d;
  logic                            w_lat_q, w_lat_d;
  logic                            awready_q, awready_d;
  logic                            wready_q, wready_d;
  logic [OPT_MEM_ADDR_BITS-1:0]    waddr_q, waddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic                            aw_hs, w_hs;
  logic                            wr_in_space;
  logic                            unused_bits;

`ifdef SAMPLER_AXI_SLVERR_EN
  assign wr_in_space = in_space(32'(waddr_q), REG_SPACE_WORDS);
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr};
`else
  assign wr_in_space = 1'b1;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr};
`endif

  assign aw_hs = s_axi_awvalid && awready_q;
  assign w_hs  = s_axi_wvalid && wready_q;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_lat_d   = aw_lat_q;
    w_lat_d    = w_lat_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          waddr_d  = s_axi_awaddr[ADDR_LSB +: OPT_MEM_ADDR_BITS];
          aw_lat_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
          w_lat_d = 1'b1;
        end
        // covers AW/W in either order as well as the same-cycle case
        if (aw_lat_d && w_lat_d) begin
          aw_lat_d   = 1'b0;
          w_lat_d    = 1'b0;
          wr_state_d = W_STROBE;
        end
      end
      W_STROBE: begin
        bresp_d    = wr_in_space ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    // ready flags are registered so they read 0 while in reset
    awready_d = (wr_state_d == W_IDLE) && !aw_lat_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_lat_d;
  end

  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      wr_state_q <= W_IDLE;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= AXI_RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_lat_q   <= aw_lat_d;
      w_lat_q    <= w_lat_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  assign s_axi_awready   = awready_q;
  assign s_axi_wready    = wready_q;
  assign s_axi_bvalid    = (wr_state_q == W_RESP);
  assign s_axi_bresp     = bresp_q;
  assign reg_addr_wr     = waddr_q;
  assign reg_data_in     = wdata_q;
  assign reg_byte_enable = wstrb_q;
  assign reg_data_wren   = (wr_state_q == W_STROBE) && wr_in_space;

  sampler_axi_lite_rd_ch #(
    .DATA_WIDTH        (C_S_AXI_DATA_WIDTH),
    .ADDR_WIDTH        (C_S_AXI_ADDR_WIDTH),
    .OPT_MEM_ADDR_BITS (OPT_MEM_ADDR_BITS),
    .REG_SPACE_WORDS   (REG_SPACE_WORDS)
  ) u_rd_ch (
    .clk_i          (axi_clk),
    .rst_ni         (axi_reset),
    .araddr_i       (s_axi_araddr),
    .arvalid_i      (s_axi_arvalid),
    .arready_o      (s_axi_arready),
    .rdata_o        (s_axi_rdata),
    .rresp_o        (s_axi_rresp),
    .rvalid_o       (s_axi_rvalid),
    .rready_i       (s_axi_rready),
    .reg_addr_rd_o  (reg_addr_rd),
    .reg_data_out_i (reg_data_out)
  );

endmodule

// File: tb/tb_sampler_axi_lite_slave.sv
// Directed self-checking bench for sampler_axi_lite_slave with a byte-enabled register file model.
module tb_sampler_axi_lite_slave;

  logic        axi_clk = 1'b0;
  logic        axi_reset;
  logic [11:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [11:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] reg_data_in;
  logic [9:0]  reg_addr_wr;
  logic        reg_data_wren;
  logic [3:0]  reg_byte_enable;
  logic [9:0]  reg_addr_rd;
  logic [31:0] reg_data_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 axi_clk = ~axi_clk;

  sampler_axi_lite_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (12),
    .OPT_MEM_ADDR_BITS  (10),
    .REG_SPACE_WORDS    (32)
  ) dut (
    .axi_clk         (axi_clk),
    .axi_reset       (axi_reset),
    .s_axi_awaddr    (s_axi_awaddr),
    .s_axi_awprot    (s_axi_awprot),
    .s_axi_awvalid   (s_axi_awvalid),
    .s_axi_awready   (s_axi_awready),
    .s_axi_wdata     (s_axi_wdata),
    .s_axi_wstrb     (s_axi_wstrb),
    .s_axi_wvalid    (s_axi_wvalid),
    .s_axi_wready    (s_axi_wready),
    .s_axi_bresp     (s_axi_bresp),
    .s_axi_bvalid    (s_axi_bvalid),
    .s_axi_bready    (s_axi_bready),
    .s_axi_araddr    (s_axi_araddr),
    .s_axi_arprot    (s_axi_arprot),
    .s_axi_arvalid   (s_axi_arvalid),
    .s_axi_arready   (s_axi_arready),
    .s_axi_rdata     (s_axi_rdata),
    .s_axi_rresp     (s_axi_rresp),
    .s_axi_rvalid    (s_axi_rvalid),
    .s_axi_rready    (s_axi_rready),
    .reg_data_in     (reg_data_in),
    .reg_addr_wr     (reg_addr_wr),
    .reg_data_wren   (reg_data_wren),
    .reg_byte_enable (reg_byte_enable),
    .reg_addr_rd     (reg_addr_rd),
    .reg_data_out    (reg_data_out)
  );

  // Register file model: unwritten word N reads as N*4.
  logic [31:0]   mem [0:1023];
  logic [1023:0] wr_seen  = '0;
  int unsigned   wren_cnt = 0;

  always @(posedge axi_clk) begin : regfile
    logic [31:0] cur;
    if (reg_data_wren) begin
      cur = wr_seen[reg_addr_wr] ? mem[reg_addr_wr] : {20'd0, reg_addr_wr, 2'b00};
      for (int b = 0; b < 4; b++)
        if (reg_byte_enable[b]) cur[8*b +: 8] = reg_data_in[8*b +: 8];
      mem[reg_addr_wr]     <= cur;
      wr_seen[reg_addr_wr] <= 1'b1;
      wren_cnt             <= wren_cnt + 1;
    end
  end

  assign reg_data_out = wr_seen[reg_addr_rd] ? mem[reg_addr_rd] : {20'd0, reg_addr_rd, 2'b00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
    bit aw_done = 0;
    bit w_done  = 0;
    bit b_seen  = 0;
    bit aw_h, w_h;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    for (int n = 0; n < 10 && !(aw_done && w_done); n++) begin
      aw_h = s_axi_awvalid && s_axi_awready;
      w_h  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_h) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_h)  begin w_done  = 1; s_axi_wvalid  = 1'b0; end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
    for (int n = 0; n < 10 && !b_seen; n++) begin
      if (s_axi_bvalid) b_seen = 1;
      else tick();
    end
    check("bvalid_wait", {31'd0, b_seen}, 32'd1);
    r = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    bit ar_done = 0;
    bit r_seen  = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    for (int n = 0; n < 10 && !ar_done; n++) begin
      ar_done = s_axi_arready;
      tick();
    end
    s_axi_arvalid = 1'b0;
    check("ar_handshake", {31'd0, ar_done}, 32'd1);
    for (int n = 0; n < 10 && !r_seen; n++) begin
      if (s_axi_rvalid) r_seen = 1;
      else tick();
    end
    check("rvalid_wait", {31'd0, r_seen}, 32'd1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    int unsigned wc0;

    axi_reset = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Reset state
    #12;
    check("rst_awready", {31'd0, s_axi_awready}, 32'd0);
    check("rst_wready", {31'd0, s_axi_wready}, 32'd0);
    check("rst_arready", {31'd0, s_axi_arready}, 32'd0);
    check("rst_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    check("rst_wren", {31'd0, reg_data_wren}, 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_addr_rd", {22'd0, reg_addr_rd}, 32'd0);
    #10 axi_reset = 1'b1;
    tick();
    check("idle_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

    // AW and W in the same cycle
    wc0 = wren_cnt;
    s_axi_awaddr = 12'h044; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hCAFE0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("t1_wren", {31'd0, reg_data_wren}, 32'd1);
    check("t1_addr_wr", {22'd0, reg_addr_wr}, 32'h11);
    check("t1_data_in", reg_data_in, 32'hCAFE0001);
    check("t1_bvalid_early", {31'd0, s_axi_bvalid}, 32'd0);
    tick();
    check("t1_wren_single", {31'd0, reg_data_wren}, 32'd0);
    check("t1_bvalid", {29'd0, s_axi_bvalid, s_axi_bresp}, {29'd0, 1'b1, 2'b00});
    tick();
    check("t1_bvalid_hold", {31'd0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("t1_bvalid_clear", {31'd0, s_axi_bvalid}, 32'd0);
    check("t1_awready_back", {31'd0, s_axi_awready}, 32'd1);
    check("t1_wren_count", wren_cnt - wc0, 32'd1);
    check("t1_mem", mem[10'h11], 32'hCAFE0001);

    // W first, AW three cycles later
    wc0 = wren_cnt;
    s_axi_wdata = 32'hFFFFBEEF; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check("t2_wready_latched", {30'd0, s_axi_wready, s_axi_awready}, 32'd1);
    tick();
    check("t2_no_wren_a", {31'd0, reg_data_wren}, 32'd0);
    tick();
    check("t2_no_wren_b", {31'd0, reg_data_wren}, 32'd0);
    s_axi_awaddr = 12'h048; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("t2_wren", {31'd0, reg_data_wren}, 32'd1);
    check("t2_byte_en", {28'd0, reg_byte_enable}, 32'h3);
    check("t2_addr_wr", {22'd0, reg_addr_wr}, 32'h12);
    tick();
    check("t2_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("t2_mem_strobed", mem[10'h12], 32'h0000BEEF);
    check("t2_wren_count", wren_cnt - wc0, 32'd1);

    // AW first: awready drops while AW waits for W
    s_axi_awaddr = 12'h04C; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("t2b_awready_latched", {30'd0, s_axi_awready, s_axi_wready}, 32'd1);
    s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check("t2b_wren", {22'd0, reg_data_wren, reg_addr_wr}, {22'd0, 1'b1, 10'h13});
    tick();
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;

    // Read word 1 with rready held low
    s_axi_araddr = 12'h004; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check("t3_rvalid_early", {31'd0, s_axi_rvalid}, 32'd0);
    tick();
    check("t3_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
    check("t3_rdata", s_axi_rdata, 32'd4);
    check("t3_rresp", {30'd0, s_axi_rresp}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", {s_axi_rvalid, s_axi_rdata[30:0]}, {1'b1, 31'd4});
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("t3_rvalid_clear", {31'd0, s_axi_rvalid}, 32'd0);
    check("t3_addr_rd_kept", {22'd0, reg_addr_rd}, 32'd1);

    // Concurrent write and read of word 0x10: sample cycle coincides with wren
    s_axi_awaddr = 12'h040; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0BADF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 12'h040; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("t4_wren_with_sample", {31'd0, reg_data_wren}, 32'd1);
    tick();
    check("t4_both_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd3);
    check("t4_old_value", s_axi_rdata, 32'h40);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    do_read(12'h040, rd, resp);
    check("t4_new_value", rd, 32'h0BADF00D);

    // Reset during W_RESP and R_VALID
    s_axi_awaddr = 12'h050; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h77777777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 12'h008; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    tick();
    tick();
    check("t5_pre_reset", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd3);
    #3 axi_reset = 1'b0;
    #1;
    check("t5_reset_async", {29'd0, s_axi_bvalid, s_axi_rvalid, reg_data_wren}, 32'd0);
    #2 axi_reset = 1'b1;
    tick();
    wc0 = wren_cnt;
    do_write(12'h008, 32'h55AA55AA, 4'hF, resp);
    check("t5_post_bresp", {30'd0, resp}, 32'd0);
    check("t5_post_wren", wren_cnt - wc0, 32'd1);
    do_read(12'h008, rd, resp);
    check("t5_post_read", rd, 32'h55AA55AA);

    // Out-of-range word 0x3FF and the REG_SPACE_WORDS boundary
    wc0 = wren_cnt;
    do_write(12'hFFC, 32'h12345678, 4'hF, resp);
`ifdef SAMPLER_AXI_SLVERR_EN
    check("t6_oor_bresp", {30'd0, resp}, 32'd2);
    check("t6_oor_wren", wren_cnt - wc0, 32'd0);
    do_read(12'hFFC, rd, resp);
    check("t6_oor_rdata", rd, 32'd0);
    check("t6_oor_rresp", {30'd0, resp}, 32'd2);
    do_read(12'h080, rd, resp);
    check("t6_edge_rresp", {30'd0, resp}, 32'd2);
    check("t6_edge_rdata", rd, 32'd0);
`else
    check("t6_oor_bresp", {30'd0, resp}, 32'd0);
    check("t6_oor_wren", wren_cnt - wc0, 32'd1);
    do_read(12'hFFC, rd, resp);
    check("t6_oor_rdata", rd, 32'h12345678);
    check("t6_oor_rresp", {30'd0, resp}, 32'd0);
    do_read(12'h080, rd, resp);
    check("t6_edge_rresp", {30'd0, resp}, 32'd0);
    check("t6_edge_rdata", rd, 32'h80);
`endif
    do_read(12'h07C, rd, resp);
    check("t6_last_word_rresp", {30'd0, resp}, 32'd0);
    check("t6_last_word_rdata", rd, 32'h7C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
